// File: rtl/randomizer_checker.sv
`default_nettype none
// ============================================================================
// Module   : randomizer_checker
// Purpose  : Consumer-side checker for the 4-bit XNOR LFSR stream
//            (next(v) = {v[2:0], ~(v[3]^v[2])}). It hunts for a run of
//            consecutive legal successors, locks on, then free-runs its own
//            prediction and counts every sample that disagrees with it.
// Ports    :
//   clk_in      in   1      system clock, rising edge
//   rst_in      in   1      asynchronous active-high reset
//   valid_in    in   1      sample strobe
//   value_in    in   4      observed LFSR value
//   clear_in    in   1      synchronous clear of err_count
//   locked      out  1      high while locked to the sequence
//   error_pulse out  1      one-cycle pulse per mismatching sample while locked
//   err_count   out  ERR_W  saturating mismatch count since reset/clear
//   expected    out  4      prediction for the next valid sample (when locked)
// Revision : 1.0 - initial release
// ============================================================================
module randomizer_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [3:0]       value_in,
  input  logic             clear_in,
  output logic             locked,
  output logic             error_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       expected
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       C_LOCKUP   = 4'hF;
  localparam logic [3:0]       C_LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0]       C_MISS_LIM = 4'(MISS_LIMIT);
  localparam logic [ERR_W-1:0] C_ERR_MAX  = '1;

  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2:0], ~(v[3] ^ v[2])};
  endfunction

  state_t     r_state;
  logic [3:0] r_prev;
  logic       r_seed_valid;
  logic [3:0] r_match_cnt;
  logic [3:0] r_miss_cnt;

  logic       w_is_lockup;
  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;
  logic       w_err_event;

  assign w_is_lockup = (value_in == C_LOCKUP);
  assign w_match_inc = r_match_cnt + 4'd1;
  assign w_miss_inc  = r_miss_cnt + 4'd1;
  // A mismatch only counts as an error once locked; HUNT never reports errors.
  assign w_err_event = valid_in && (r_state == ST_LOCKED) && (value_in != expected);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= ST_HUNT;
      r_prev       <= 4'd0;
      r_seed_valid <= 1'b0;
      r_match_cnt  <= 4'd0;
      r_miss_cnt   <= 4'd0;
      locked       <= 1'b0;
      error_pulse  <= 1'b0;
      err_count    <= '0;
      expected     <= 4'd0;
    end else begin
      error_pulse <= w_err_event;

      // Clear takes priority over a simultaneous increment.
      if (clear_in) begin
        err_count <= '0;
      end else if (w_err_event && (err_count != C_ERR_MAX)) begin
        err_count <= err_count + 1'b1;
      end

      if (valid_in) begin
        case (r_state)
          ST_HUNT: begin
            if (w_is_lockup) begin
              // Lockup value breaks any chain; the next legal sample reseeds.
              r_seed_valid <= 1'b0;
              r_match_cnt  <= 4'd0;
            end else begin
              r_prev <= value_in;
              if (!r_seed_valid) begin
                r_seed_valid <= 1'b1;
                r_match_cnt  <= 4'd0;
              end else if (value_in == lfsr_next(r_prev)) begin
                r_match_cnt <= w_match_inc;
                if (w_match_inc == C_LOCK_CNT) begin
                  r_state    <= ST_LOCKED;
                  locked     <= 1'b1;
                  expected   <= lfsr_next(value_in);
                  r_miss_cnt <= 4'd0;
                end
              end else begin
                r_match_cnt <= 4'd0;
              end
            end
          end

          ST_LOCKED: begin
            // Prediction free-runs; the input never reseeds it while locked.
            expected <= lfsr_next(expected);
            if (value_in == expected) begin
              r_miss_cnt <= 4'd0;
            end else if (w_miss_inc == C_MISS_LIM) begin
              r_state      <= ST_HUNT;
              locked       <= 1'b0;
              r_match_cnt  <= 4'd0;
              r_miss_cnt   <= 4'd0;
              // The sample that broke lock becomes the seed for re-acquisition.
              r_seed_valid <= !w_is_lockup;
              if (!w_is_lockup) begin
                r_prev <= value_in;
              end
            end else begin
              r_miss_cnt <= w_miss_inc;
            end
          end

          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/randomizer_checker.md
# randomizer_checker

Consumer-side checker for the 4-bit XNOR LFSR stream used throughout the game logic. Next-state function: next(v) = {v[2:0], ~(v[3]^v[2])}. The block samples a stream of LFSR values, acquires lock onto the sequence, predicts every subsequent value, and counts mismatches. It sits downstream of the randomizer or its consumers (spawner, debug tap), and provides a lock indicator and an error counter for self-test and on-screen debug.

## Interface

- LOCK_COUNT, 4: consecutive correct predictions needed in HUNT before entering LOCKED (1..15).
- MISS_LIMIT, 3: consecutive mismatches in LOCKED that force a return to HUNT (1..15).
- ERR_W, 16: width of the saturating error counter.
- clk_in  input  1  single system clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- valid_in  input  1  the sample strobe; value_in is consumed only on cycles where valid_in=1.
- value_in  input  4  observed LFSR value.
- clear_in  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- error_pulse  output  1  one-cycle pulse per mismatching sample in LOCKED.
- err_count  output  ERR_W  total mismatches since reset/clear, saturating at all-ones.
- expected  output  4  prediction for the next valid sample; meaningful only while locked=1.

## Operation

- Legal sequence has period 15: 0000→0001→0011→0111→1110→1101→1011→0110→1100→1001→0010→0101→1010→0100→1000→0000. 1111 is the lockup state and is illegal.
- Reset (async): state=HUNT, seed_valid=0, match_cnt=0, miss_cnt=0, locked=0, error_pulse=0, err_count=0, expected=0000.
- HUNT, on each valid sample:
  - If value_in=1111: seed_valid←0 and match_cnt←0. No error is counted.
  - Else if seed_valid=0: prev←value_in, seed_valid←1, match_cnt←0.
  - Else if value_in=next(prev): match_cnt←match_cnt+1.
  - Else: match_cnt←0.
  - For any non-1111 sample, prev←value_in, so the checker always resyncs to the latest sample.
  - When a match makes match_cnt reach LOCK_COUNT: state←LOCKED, expected←next(value_in), miss_cnt←0.
- LOCKED, on each valid sample:
  - expected←next(expected). The prediction is free-running and is never reseeded from the input.
  - If value_in=expected: miss_cnt←0.
  - Else: error_pulse←1, err_count←err_count+1 (saturating), miss_cnt←miss_cnt+1.
  - If this mismatch makes miss_cnt reach MISS_LIMIT: state←HUNT and match_cnt←0. The current sample seeds prev (seed_valid←1) unless it is 1111, in which case seed_valid←0.
  - A 1111 sample in LOCKED is an ordinary mismatch.
- Cycles with valid_in=0 leave all state unchanged; error_pulse is 0.
- clear_in=1: err_count←0. If clear_in and a mismatch occur in the same cycle, clear wins (err_count=0) and error_pulse still asserts.
- Saturation: at err_count=2^ERR_W−1, further errors hold the value; error_pulse still fires.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Lock latency: locked rises in the cycle after the edge that samples the LOCK_COUNT-th consecutive match, i.e. after LOCK_COUNT+1 valid samples from a clean start.
- error_pulse is high for exactly the cycle following the edge that sampled the mismatch. err_count updates on that same edge.
- Unlock: locked falls in the cycle after the MISS_LIMIT-th consecutive mismatch.
- Back-to-back valid samples every cycle are supported. Throughput is one sample per clock.
- Asserting rst_in mid-operation immediately forces all outputs to their reset values, independent of clk_in.

## Test plan

- Lock from randomizer reset: feed 0000,0001,0011,0111,1110 on consecutive cycles → locked=1 the cycle after 1110 is sampled, expected=1101, err_count=0. Run 100 further correct samples → no error_pulse.
- Single error while locked: after lock, substitute 0000 for an expected 1101, then resume the correct sequence → exactly one error_pulse, err_count=1, locked stays 1, and expected follows the true sequence (1011 next).
- Loss of lock: after lock, inject 3 consecutive wrong values → err_count=3, locked=0 after the third. Then feed 4 correct successors of the third sample → relock.
- Lockup value in HUNT: feed 0000,0001,1111,0011,0111 → no lock and no error. A valid chain only starts from 0011, so locked asserts only after 0011,0111,1110,1101,1011.
- Gaps and clear: lock with valid_in toggling 1/0 → same lock result as with contiguous valid. Pulse clear_in in the same cycle as a mismatch → err_count=0 and error_pulse=1.
- Saturation and async reset: ERR_W=2, force 5 isolated errors (MISS_LIMIT not reached) → err_count stays 3 with 5 pulses. Then assert rst_in between clock edges → locked=0, err_count=0 and expected=0000 immediately.
